aes_stream_bridge: RTL and testbench

//  Byte-stream front end for aes_core in the spi_aes design. Sits between the SPI byte layer and aes_core.

---
 rtl/aes_stream_bridge_pkg.sv | 35 +++
 rtl/aes_tx_serializer.sv | 41 ++++
 rtl/aes_stream_bridge.sv | 185 ++++++++++++++++++
 tb/tb_aes_stream_bridge.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_bridge_pkg.sv
// rtl/aes_stream_bridge_pkg.sv - shared state encodings, size codes and command fields for aes_stream_bridge
package aes_stream_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_DATA = 3'd2,
    ST_LOAD = 3'd3,
    ST_WAIT = 3'd4,
    ST_SEND = 3'd5
  } state_t;

  localparam logic [1:0] AES_128 = 2'd0;
  localparam logic [1:0] AES_192 = 2'd1;
  localparam logic [1:0] AES_256 = 2'd2;
  localparam logic [1:0] AES_BAD = 2'd3;

  localparam int CMD_DEC_BIT   = 2;
  localparam int CMD_REUSE_BIT = 3;

  localparam logic [5:0] KEY_BYTES_128 = 6'd16;
  localparam logic [5:0] KEY_BYTES_192 = 6'd24;
  localparam logic [5:0] KEY_BYTES_256 = 6'd32;
  localparam logic [5:0] DATA_LAST_IDX = 6'd15;

  // Index of the final key byte for a given size code.
  function automatic logic [5:0] key_last_idx(input logic [1:0] size);
    case (size)
      AES_192: return KEY_BYTES_192 - 6'd1;
      AES_256: return KEY_BYTES_256 - 6'd1;
      default: return KEY_BYTES_128 - 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/aes_tx_serializer.sv
// rtl/aes_tx_serializer.sv - 128-bit parallel load to MSB-first byte valid/ready stream with done pulse
module aes_tx_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] load_data,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         done
);

  logic [127:0] shreg;
  logic [3:0]   byte_cnt;
  logic         active;

  assign tx_data  = shreg[127:120];
  assign tx_valid = active;
  // done is combinational so the owner FSM can leave SEND on the same edge as the last transfer
  assign done     = active & tx_ready & (byte_cnt == 4'd15);

  // Shift register: load a block, then shift one byte out per accepted transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
      active   <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      byte_cnt <= '0;
      active   <= 1'b1;
    end else if (active && tx_ready) begin
      shreg    <= {shreg[119:0], 8'h00};
      byte_cnt <= byte_cnt + 4'd1;
      if (byte_cnt == 4'd15) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aes_stream_bridge.sv
// rtl/aes_stream_bridge.sv - byte-stream front end for aes_core; optional rx inactivity timeout via AESB_TIMEOUT_EN
module aes_stream_bridge #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         core_load,
  output logic [255:0] core_key,
  output logic [127:0] core_data,
  output logic [1:0]   core_size,
  output logic         core_dec,
  input  logic [127:0] core_result,
  input  logic         core_busy,
  output logic         busy_o,
  output logic         err_o
);

  import aes_stream_bridge_pkg::*;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt;
  logic       rx_fire;
  logic       ser_load;
  logic       ser_done;
  logic       timeout_hit;
  logic [7:0] key_msb;
  logic [6:0] data_msb;

  assign rx_ready  = (state == ST_IDLE) || (state == ST_KEY) || (state == ST_DATA);
  assign rx_fire   = rx_valid & rx_ready;
  assign core_load = (state == ST_LOAD);
  assign busy_o    = (state != ST_IDLE);
  assign key_msb   = 8'd255 - {cnt[4:0], 3'b000};
  assign data_msb  = 7'd127 - {cnt[3:0], 3'b000};

`ifdef AESB_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        in_rx_phase;

  assign in_rx_phase = (state == ST_KEY) || (state == ST_DATA);
  assign timeout_hit = in_rx_phase && !rx_fire && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Count consecutive KEY/DATA cycles without an accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (in_rx_phase && !rx_fire && !timeout_hit) begin
      idle_cnt <= idle_cnt + 32'd1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and serializer load strobe
  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_data[1:0] != AES_BAD)) begin
          state_nxt = rx_data[CMD_REUSE_BIT] ? ST_DATA : ST_KEY;
        end
      end
      ST_KEY: begin
        if (timeout_hit) begin
          state_nxt = ST_IDLE;
        end else if (rx_valid && (cnt == key_last_idx(core_size))) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (timeout_hit) begin
          state_nxt = ST_IDLE;
        end else if (rx_valid && (cnt == DATA_LAST_IDX)) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt is 0 only in the first WAIT cycle, before the core has raised busy
        if ((cnt != 6'd0) && !core_busy) begin
          ser_load  = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Rx datapath: command decode, key/data byte placement, phase byte counter, error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      core_key  <= '0;
      core_data <= '0;
      core_size <= AES_128;
      core_dec  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (rx_fire && (state != ST_IDLE)) begin
        cnt <= cnt + 6'd1;
      end else if (state == ST_WAIT) begin
        cnt <= 6'd1;
      end

      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            if (rx_data[1:0] == AES_BAD) begin
              err_o <= 1'b1;
            end else begin
              err_o     <= 1'b0;
              core_size <= rx_data[1:0];
              core_dec  <= rx_data[CMD_DEC_BIT];
              if (!rx_data[CMD_REUSE_BIT]) begin
                core_key <= '0;
              end
            end
          end
        end
        ST_KEY: begin
          if (rx_fire) begin
            core_key[key_msb -: 8] <= rx_data;
          end
        end
        ST_DATA: begin
          if (rx_fire) begin
            core_data[data_msb -: 8] <= rx_data;
          end
        end
        default: begin
        end
      endcase

      if (timeout_hit) begin
        err_o <= 1'b1;
      end
    end
  end

  aes_tx_serializer u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (core_result),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (ser_done)
  );

endmodule

// File: tb/tb_aes_stream_bridge.sv
// tb/tb_aes_stream_bridge.sv - self-checking bench for aes_stream_bridge with a behavioural AES core behind it
module tb_aes_stream_bridge;

`ifdef AESB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 50;
`else
  localparam int TB_TIMEOUT = 1000000;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         core_load;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic [1:0]   core_size;
  logic         core_dec;
  logic [127:0] core_result = '0;
  logic         core_busy = 1'b0;
  logic         busy_o;
  logic         err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int core_lat = 0;
  int load_pulses = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  aes_stream_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .core_load   (core_load),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_size   (core_size),
    .core_dec    (core_dec),
    .core_result (core_result),
    .core_busy   (core_busy),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      sbox_t[x]  = s;
      isbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [7:0] b;
    for (int n = 0; n < 16; n++) begin
      b = s[127-8*n -: 8];
      s[127-8*n -: 8] = inv ? isbox_t[b] : sbox_t[b];
    end
    return s;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] o;
    o = '0;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(a[j], m[(j - i + 4) % 4]);
        o[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // FIPS-197 cipher / inverse cipher on a left-aligned key
  function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [1:0] size,
                                           input logic dec, input logic [127:0] din);
    int nk;
    int nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [127:0] s;
    nk = 4 + 2 * int'(size);
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    if (!dec) begin
      s = din ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= nr; r++) begin
        s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
        if (r < nr) s = mix_cols(s, 1'b0);
        s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
    end else begin
      s = din ^ {w[4*nr], w[4*nr+1], w[4*nr+2], w[4*nr+3]};
      for (int r = nr - 1; r >= 0; r--) begin
        s = sub_bytes(shift_rows(s, 1'b1), 1'b1);
        s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        if (r > 0) s = mix_cols(s, 1'b1);
      end
    end
    return s;
  endfunction

  // Behavioural aes_core: busy one cycle after load, random latency, result valid when busy drops
  always @(posedge clk) begin
    if (core_load) begin
      load_pulses <= load_pulses + 1;
      core_busy   <= 1'b1;
      core_lat    <= int'($urandom_range(1, 10));
    end else if (core_busy) begin
      if (core_lat <= 1) begin
        core_busy   <= 1'b0;
        core_result <= aes_ref(core_key, core_size, core_dec, core_data);
      end else begin
        core_lat <= core_lat - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctl"}, {rx_ready, tx_valid, tx_data, core_load, core_size, core_dec, busy_o, err_o},
          {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
    check({tag, "_key"}, core_key, '0);
    check({tag, "_data"}, core_data, '0);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n;
    n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("rx_ready_wait", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic recv_block(output logic [127:0] got, input bit rnd);
    int k;
    int n;
    k = 0;
    n = 0;
    got = '0;
    while (k < 16 && n < 5000) begin
      tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (tx_valid && tx_ready) begin
        got = {got[119:0], tx_data};
        k++;
      end
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    if (k < 16) check("tx_bytes_wait", 32'(k), 32'd16);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [255:0] key,
                           input logic [127:0] data, input logic [127:0] exp, input bit rnd, input int hold);
    int nk;
    int lp;
    int n;
    bit stable;
    logic [7:0] d0;
    logic [127:0] got;
    nk = cmd[3] ? 0 : 16 + 8 * int'(cmd[1:0]);
    lp = load_pulses;
    send_byte(cmd, rnd);
    check({tag, "_err_after_cmd"}, {busy_o, err_o}, {1'b1, 1'b0});
    for (int i = 0; i < nk; i++) send_byte(key[255-8*i -: 8], rnd);
    for (int i = 0; i < 16; i++) send_byte(data[127-8*i -: 8], rnd);
    check({tag, "_load_latency"}, {core_load, rx_ready}, {1'b1, 1'b0});
    if (hold > 0) begin
      n = 0;
      while (!tx_valid && n < 1000) begin
        @(negedge clk);
        n++;
      end
      d0 = tx_data;
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (tx_data !== d0 || tx_valid !== 1'b1) stable = 1'b0;
      end
      check({tag, "_stall_stable"}, stable, 1'b1);
      check({tag, "_stall_first"}, d0, exp[127:120]);
    end
    recv_block(got, rnd);
    check(tag, got, exp);
    check({tag, "_load_pulses"}, 32'(load_pulses - lp), 32'd1);
    check({tag, "_idle_after"}, {busy_o, tx_valid, rx_ready}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [255:0] key128;
    logic [255:0] key192;
    logic [255:0] key256;
    logic [127:0] pt;
    logic [127:0] ct128;
    logic [127:0] ct192;
    logic [127:0] ct256;
    logic [255:0] mkey;
    logic [255:0] mask;
    logic [127:0] rdata;
    logic [1:0]   sz;
    logic         dc;
    logic         ru;

    key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pt     = 128'h00112233445566778899aabbccddeeff;
    ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    init_sbox();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    run_frame("fips128_enc", 8'h00, key128, pt, ct128, 1'b0, 0);
    check("fips128_key_reg", core_key, key128);
    run_frame("fips128_dec_reuse", 8'h0C, key128, ct128, pt, 1'b1, 0);
    run_frame("fips256_enc", 8'h02, key256, pt, ct256, 1'b1, 0);
    run_frame("fips192_enc", 8'h01, key192, pt, ct192, 1'b0, 0);
    check("fips192_key_zero_pad", core_key, key192);

    send_byte(8'h03, 1'b0);
    check("bad_size", {err_o, busy_o, rx_ready, core_size}, {1'b1, 1'b0, 1'b1, 2'd1});
    run_frame("after_bad", 8'h00, key128, pt, ct128, 1'b0, 0);
    run_frame("cmd_high_ignored", 8'hF0, key128, pt, ct128, 1'b1, 0);

    run_frame("backpressure", 8'h00, key128, pt, ct128, 1'b0, 20);

    mkey = '0;
    for (int t = 0; t < 8; t++) begin
      sz = 2'($urandom_range(0, 2));
      dc = 1'($urandom_range(0, 1));
      ru = (t != 0) && ($urandom_range(0, 1) == 1);
      if (!ru) begin
        mask = {256{1'b1}} << (256 - 8 * (16 + 8 * int'(sz)));
        mkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} & mask;
      end
      rdata = {$urandom, $urandom, $urandom, $urandom};
      run_frame($sformatf("rand%0d", t), {4'h0, ru, dc, sz}, mkey, rdata, aes_ref(mkey, sz, dc, rdata), 1'b1, 0);
    end

    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(key128[255-8*i -: 8], 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pt[127-8*i -: 8], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("rst_mid_data");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame("after_rst", 8'h00, key128, pt, ct128, 1'b1, 0);

`ifdef AESB_TIMEOUT_EN
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(key128[255-8*i -: 8], 1'b0);
    for (int i = 0; i < 5; i++) send_byte(pt[127-8*i -: 8], 1'b0);
    repeat (49) @(negedge clk);
    check("timeout_before", {busy_o, err_o}, {1'b1, 1'b0});
    @(negedge clk);
    check("timeout_hit", {busy_o, err_o, rx_ready}, {1'b0, 1'b1, 1'b1});
    run_frame("after_timeout", 8'h00, key128, pt, ct128, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
